execute_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the Execute stage, fed by the Decode-to-Execute pipeline register: operands, plus an op code decoded from the ALU control.
- Holds the architectural HI/LO registers.
- Asserts Busy while iterating, so hazard logic stalls Decode/Fetch and bubbles Execute.
- 32-cycle radix-2 shift-add multiply and restoring divide, one fix-up cycle.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_div_step.sv | 23 ++
 rtl/execute_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the Execute-stage iterative multiply/divide unit.
// The optional MADD/MSUB accumulate path is enabled by MULDIV_MADD_EN.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic op_signed(input op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] sh;
  logic [W:0] dvs_x;
  logic       ge;

  assign sh    = {rem_i, quo_i[W-1]};
  assign dvs_x = {1'b0, dvs_i};
  assign ge    = (sh >= dvs_x);
  assign rem_o = W'(ge ? sh - dvs_x : sh);
  assign quo_o = {quo_i[W-2:0], ge};

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative mul/div unit holding HI/LO; Busy stalls the front end.
// MULDIV_MADD_EN enables MADD/MSUB accumulation into {HI,LO}.
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             Kill,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;

  op_e              op_in;
  logic             sgn_in, div_in, acc_ok, is_div;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   msum;
  logic [W2-1:0]    mul_nxt, div_nxt, prod_s;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_s, rem_s;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign op_in  = op_e'(Op);
  assign sgn_in = op_signed(op_in);
  assign div_in = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign a_abs  = (sgn_in && RsData[WIDTH-1]) ? -RsData : RsData;
  assign b_abs  = (sgn_in && RtData[WIDTH-1]) ? -RtData : RtData;

`ifdef MULDIV_MADD_EN
  assign acc_ok = (op_in != OP_MTHI) && (op_in != OP_MTLO);
`else
  assign acc_ok = op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif

  // Product register holds {partial sum, remaining multiplier bits}
  assign msum    = {1'b0, prod_q[W2-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_nxt = {msum, prod_q[WIDTH-1:1]};

  muldiv_div_step #(.W(WIDTH)) u_div_step (
    .rem_i (prod_q[W2-1:WIDTH]),
    .quo_i (prod_q[WIDTH-1:0]),
    .dvs_i (mcand_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  assign div_nxt = {rem_nxt, quo_nxt};
  assign prod_s  = qneg_q ? -prod_q : prod_q;
  assign quo_s   = qneg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_s   = rneg_q ? -prod_q[W2-1:WIDTH] : prod_q[W2-1:WIDTH];

  always_comb begin
    {fin_hi, fin_lo} = prod_s;
    if (is_div) begin
      fin_hi = rem_s;
      fin_lo = quo_s;
    end
`ifdef MULDIV_MADD_EN
    else if (op_q == OP_MADD) begin
      {fin_hi, fin_lo} = {hi_q, lo_q} + prod_s;
    end else if (op_q == OP_MSUB) begin
      {fin_hi, fin_lo} = {hi_q, lo_q} - prod_s;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Kill) begin
          unique case (1'b1)
            op_in == OP_MTHI: hi_d = RsData;
            op_in == OP_MTLO: lo_d = RsData;
            acc_ok: begin
              op_d    = op_in;
              cnt_d   = '0;
              state_d = RUN;
              prod_d  = {{WIDTH{1'b0}}, div_in ? a_abs : b_abs};
              mcand_d = div_in ? b_abs : a_abs;
              qneg_d  = sgn_in && (RsData[WIDTH-1] ^ RtData[WIDTH-1]);
              rneg_d  = sgn_in && div_in && RsData[WIDTH-1];
              // x/0 keeps all-ones quotient; remainder fix-up restores RsData
              if (div_in && (RtData == '0)) qneg_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (Kill) begin
          state_d = IDLE;
        end else begin
          prod_d = is_div ? div_nxt : mul_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!Kill) begin
          hi_d   = fin_hi;
          lo_d   = fin_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed and random bench for execute_muldiv_unit against an arithmetic
// model of HI/LO; honours MULDIV_MADD_EN the same way as the design.
module tb_execute_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] RsData = '0;
  logic [31:0] RtData = '0;
  logic        Kill = 1'b0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  execute_muldiv_unit dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .RsData (RsData),
    .RtData (RtData),
    .Kill   (Kill),
    .Busy   (Busy),
    .Done   (Done),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit madd_on();
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_long(input logic [2:0] op);
    if (op == 3'b110 || op == 3'b111) return 1'b0;
    if ((op == 3'b100 || op == 3'b101) && !madd_on()) return 1'b0;
    return 1'b1;
  endfunction

  // Architectural result of one accepted operation on {m_hi, m_lo}
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    case (op)
      3'b000: {m_hi, m_lo} = p;
      3'b001: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
      3'b010, 3'b011: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = '1;
        end else if (op == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'b100: if (madd_on()) {m_hi, m_lo} = {m_hi, m_lo} + p;
      3'b101: if (madd_on()) {m_hi, m_lo} = {m_hi, m_lo} - p;
      3'b110: m_hi = a;
      default: m_lo = a;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    bit lng;
    lng = is_long(op);
    @(negedge Clk);
    Start = 1'b1; Op = op; RsData = a; RtData = b;
    @(negedge Clk);
    Start = 1'b0;
    model(op, a, b);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    chk({tag, ".busy"}, 64'(n), lng ? 64'd33 : 64'd0);
    chk({tag, ".done"}, 64'(Done), 64'(lng));
    chk({tag, ".hi"}, 64'(HI), 64'(m_hi));
    chk({tag, ".lo"}, 64'(LO), 64'(m_lo));
    @(negedge Clk);
    chk({tag, ".done_off"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int dn, n;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("rst.busy", 64'(Busy), 64'd0);
    chk("rst.done", 64'(Done), 64'd0);
    chk("rst.hi", 64'(HI), 64'd0);
    chk("rst.lo", 64'(LO), 64'd0);

    do_op("mult", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult.k_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("mult.k_lo", 64'(LO), 64'hFFFF_FFFA);
    do_op("multu", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("multu.k_hi", 64'(HI), 64'h0000_0002);
    do_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2);
    chk("div.k_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("div.k_hi", 64'(HI), 64'hFFFF_FFFF);
    do_op("divu0", 3'b011, 32'd100, 32'd0);
    chk("divu0.k_hi", 64'(HI), 64'd100);
    do_op("div0s", 3'b010, 32'hFFFF_FF00, 32'd0);
    do_op("ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf.k_lo", 64'(LO), 64'h8000_0000);
    chk("ovf.k_hi", 64'(HI), 64'd0);

    do_op("mthi", 3'b110, 32'h1234_5678, 32'd0);
    chk("mthi.k_hi", 64'(HI), 64'h1234_5678);
    do_op("mthi0", 3'b110, 32'd0, 32'd0);
    do_op("mtlo", 3'b111, 32'd10, 32'd0);
    do_op("madd", 3'b100, 32'd3, 32'd4);
    if (madd_on()) chk("madd.k_lo", 64'(LO), 64'd22);
    else chk("madd.k_lo", 64'(LO), 64'd10);
    do_op("msub", 3'b101, 32'hFFFF_FFFF, 32'd5);

    // Kill in the fifth busy cycle of MULTU 5x7
    @(negedge Clk);
    Start = 1'b1; Op = 3'b001; RsData = 32'd5; RtData = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Kill = 1'b1;
    @(negedge Clk);
    Kill = 1'b0;
    chk("kill.busy", 64'(Busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    chk("kill.done", 64'(dn), 64'd0);
    chk("kill.hi", 64'(HI), 64'(m_hi));
    chk("kill.lo", 64'(LO), 64'(m_lo));

    // Kill together with Start in IDLE
    @(negedge Clk);
    Start = 1'b1; Kill = 1'b1; Op = 3'b110; RsData = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0; Kill = 1'b0;
    chk("killst.busy", 64'(Busy), 64'd0);
    chk("killst.hi", 64'(HI), 64'(m_hi));

    // Second Start while busy is dropped
    @(negedge Clk);
    Start = 1'b1; Op = 3'b011; RsData = 32'd1000; RtData = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    model(3'b011, 32'd1000, 32'd7);
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 3'b000; RsData = 32'd3; RtData = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (!Done && n < 100) begin
      n++;
      @(negedge Clk);
    end
    chk("sbusy.done", 64'(Done), 64'd1);
    chk("sbusy.hi", 64'(HI), 64'(m_hi));
    chk("sbusy.lo", 64'(LO), 64'(m_lo));
    @(negedge Clk);
    chk("sbusy.noq", 64'(Busy), 64'd0);

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 1) rb = '0;
      if (i % 4 == 2) begin
        ra = 32'($urandom_range(0, 300)) - 32'd150;
        rb = 32'($urandom_range(0, 20)) - 32'd10;
      end
      do_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // Reset ten cycles into a DIVU
    do_op("pre", 3'b111, 32'hA5A5_0001, 32'd0);
    @(negedge Clk);
    Start = 1'b1; Op = 3'b011; RsData = 32'd12345; RtData = 32'd11;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rrun.busy", 64'(Busy), 64'd0);
    chk("rrun.hi", 64'(HI), 64'd0);
    chk("rrun.lo", 64'(LO), 64'd0);
    chk("rrun.done", 64'(Done), 64'd0);
    m_hi = '0;
    m_lo = '0;
    do_op("post", 3'b000, 32'd6, 32'hFFFF_FFF9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
